fetch_queue_ctrl: RTL and testbench

Front-end sequencer between the instruction memory port and the instruction queue. It issues in-order fetch requests, throttles them against queue occupancy and an outstanding-request limit, and pushes {pc, instr} entries into the queue. On a backend redirect it flushes the queue, restarts fetch at the new PC and discards in-flight responses that are now stale.

---
 rtl/fetch_pkg.sv | 30 +++
 rtl/fetch_queue_ctrl_sva.sv | 41 ++++
 rtl/fetch_queue_ctrl.sv | 155 +++++++++++++++
 tb/tb_fetch_queue_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch front end.
//   fetch_state_t : fetch sequencer state (RUN = normal fetch, DRAIN = waiting
//                   for stale in-flight responses after a redirect)
//   fetch_entry_t : one instruction-queue entry, {pc, instr}
//   RESET_PC      : first fetch address after reset
//   PC_STEP       : byte distance between consecutive instruction words
// -----------------------------------------------------------------------------
package fetch_pkg;

   typedef enum logic [0:0] {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   localparam logic [31:0] RESET_PC = 32'h1eceb000;
   localparam logic [31:0] PC_STEP  = 32'd4;

   // Fetch addresses are word aligned; the two low address bits are dropped.
   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_queue_ctrl_sva.sv
// -----------------------------------------------------------------------------
// fetch_queue_ctrl_sva
// Protocol checker bound into every fetch_queue_ctrl instance.
//   - no response may arrive while nothing is in flight
//   - in-flight count never exceeds MAX_OUTSTANDING
//   - an unaccepted request stays asserted with a stable address unless a
//     redirect withdraws it
//   - a queue flush and a queue push never coincide
// Ports mirror the observed signals of fetch_queue_ctrl.
// -----------------------------------------------------------------------------
module fetch_queue_ctrl_sva #(
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input logic                                  clk,
   input logic                                  rst,
   input logic                                  redirect_valid,
   input logic                                  imem_req,
   input logic [31:0]                           imem_addr,
   input logic                                  imem_ready,
   input logic                                  imem_resp,
   input logic                                  q_write_enable,
   input logic                                  q_flush,
   input logic [$clog2(MAX_OUTSTANDING+1)-1:0]  outstanding
);
   localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

   a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
      imem_resp |-> (outstanding != {CNT_W{1'b0}}));

   a_max_outstanding: assert property (@(posedge clk) disable iff (!rst)
      outstanding <= CNT_W'(MAX_OUTSTANDING));

   a_req_hold: assert property (@(posedge clk) disable iff (!rst)
      (imem_req && !imem_ready && !redirect_valid) |=> (imem_req && $stable(imem_addr)));

   a_flush_excl: assert property (@(posedge clk) disable iff (!rst)
      !(q_flush && q_write_enable));

endmodule

bind fetch_queue_ctrl fetch_queue_ctrl_sva u_fetch_queue_ctrl_sva (.*);

// File: rtl/fetch_queue_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_queue_ctrl
// Front-end sequencer between the instruction memory port and the instruction
// queue. Issues in-order fetches, throttles them against queue space and an
// in-flight limit, pushes {pc, instr} entries, and on a redirect flushes the
// queue, restarts at the new PC and discards stale in-flight responses.
//
// Ports:
//   clk, rst          clock; synchronous active-low reset
//   redirect_valid/pc backend redirect pulse and new fetch PC
//   imem_req/addr     fetch request (registered, held until accepted)
//   imem_ready        memory accepts the request this cycle
//   imem_resp/rdata   in-order response and fetched instruction
//   queue_full_param  queue has too few free slots for new fetches
//   q_data_in/q_write_enable  queue push of {resp_pc, instr}
//   q_flush           single-cycle queue clear
//   outstanding       accepted-but-unanswered request count
// -----------------------------------------------------------------------------
module fetch_queue_ctrl #(
   parameter int unsigned MAX_OUTSTANDING = 4,
   parameter logic [31:0] RESET_PC        = 32'h1eceb000,
   parameter int unsigned DATA_WIDTH      = 64
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   redirect_valid,
   input  logic [31:0]                            redirect_pc,
   output logic                                   imem_req,
   output logic [31:0]                            imem_addr,
   input  logic                                   imem_ready,
   input  logic                                   imem_resp,
   input  logic [31:0]                            imem_rdata,
   input  logic                                   queue_full_param,
   output logic [DATA_WIDTH-1:0]                  q_data_in,
   output logic                                   q_write_enable,
   output logic                                   q_flush,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding
);
   import fetch_pkg::*;

   localparam int unsigned      CNT_W    = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
   localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};

   fetch_state_t     state_q, state_d;
   logic [31:0]      fetch_pc_q, fetch_pc_d;
   logic [31:0]      resp_pc_q, resp_pc_d;
   logic [CNT_W-1:0] outstanding_q, outstanding_d;
   logic             imem_req_q, imem_req_d;
   logic             q_we_q, q_we_d;
   logic             q_flush_q, q_flush_d;
   fetch_entry_t     q_data_q, q_data_d;
   logic             accept_s;
   logic             resp_s;

   assign accept_s = imem_req_q & imem_ready;
   // A response with nothing in flight is a protocol error; it is ignored so
   // the counter can never wrap below zero.
   assign resp_s   = imem_resp & (outstanding_q != ZERO_CNT);

   // Next-state, in-flight counter, PC tracking, queue push and request issue.
   always_comb begin
      state_d       = state_q;
      fetch_pc_d    = fetch_pc_q;
      resp_pc_d     = resp_pc_q;
      outstanding_d = outstanding_q + CNT_W'(accept_s) - CNT_W'(resp_s);
      imem_req_d    = 1'b0;
      q_we_d        = 1'b0;
      q_flush_d     = 1'b0;
      q_data_d      = q_data_q;

      if (accept_s) begin
         fetch_pc_d = fetch_pc_q + PC_STEP;
      end else begin
         fetch_pc_d = fetch_pc_q;
      end

      if (redirect_valid) begin
         // Everything still in flight (including a request accepted this
         // very cycle) now belongs to the wrong path.
         fetch_pc_d = align_word(redirect_pc);
         resp_pc_d  = align_word(redirect_pc);
         q_flush_d  = 1'b1;
         if (outstanding_d != ZERO_CNT) begin
            state_d = DRAIN;
         end else begin
            state_d = RUN;
         end
      end else begin
         case (state_q)
            RUN: begin
               if (resp_s) begin
                  q_we_d    = 1'b1;
                  q_data_d  = '{pc: resp_pc_q, instr: imem_rdata};
                  resp_pc_d = resp_pc_q + PC_STEP;
               end else begin
                  q_we_d    = 1'b0;
               end
            end
            DRAIN: begin
               if (outstanding_d == ZERO_CNT) begin
                  state_d = RUN;
               end else begin
                  state_d = DRAIN;
               end
            end
            default: begin
               state_d = RUN;
            end
         endcase
      end

      // A pending request is held until accepted; only a redirect drops it.
      if (redirect_valid) begin
         imem_req_d = 1'b0;
      end else if (imem_req_q && !accept_s) begin
         imem_req_d = 1'b1;
      end else if ((state_d == RUN) && (outstanding_d < MAX_CNT) && !queue_full_param) begin
         imem_req_d = 1'b1;
      end else begin
         imem_req_d = 1'b0;
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= RUN;
         fetch_pc_q    <= RESET_PC;
         resp_pc_q     <= RESET_PC;
         outstanding_q <= ZERO_CNT;
         imem_req_q    <= 1'b0;
         q_we_q        <= 1'b0;
         q_flush_q     <= 1'b0;
         q_data_q      <= '{pc: 32'h0000_0000, instr: 32'h0000_0000};
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         resp_pc_q     <= resp_pc_d;
         outstanding_q <= outstanding_d;
         imem_req_q    <= imem_req_d;
         q_we_q        <= q_we_d;
         q_flush_q     <= q_flush_d;
         q_data_q      <= q_data_d;
      end
   end

   assign imem_req       = imem_req_q;
   assign imem_addr      = fetch_pc_q;
   assign q_data_in      = q_data_q;
   assign q_write_enable = q_we_q;
   assign q_flush        = q_flush_q;
   assign outstanding    = outstanding_q;

endmodule

// File: tb/tb_fetch_queue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue_ctrl
// Directed bench for fetch_queue_ctrl. A small memory model records accepted
// requests (marking them stale on redirect), answers them with 1-cycle latency
// when enabled, and pushes the expected queue entry for every live response
// into a scoreboard that is popped on the following cycle.
// -----------------------------------------------------------------------------
module tb_fetch_queue_ctrl;

   localparam logic [31:0] RST_PC = 32'h1eceb000;

   typedef struct {
      logic [31:0] addr;
      logic        stale;
   } req_t;

   logic        clk;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_resp;
   logic [31:0] imem_rdata;
   logic        queue_full_param;
   logic [63:0] q_data_in;
   logic        q_write_enable;
   logic        q_flush;
   logic [2:0]  outstanding;

   int          checks = 0;
   int          errors = 0;
   logic        resp_en;
   logic        junk_resp;
   logic [31:0] exp_pc;
   req_t        reqq[$];
   logic [63:0] sb[$];

   fetch_queue_ctrl dut (
      .clk              (clk),
      .rst              (rst),
      .redirect_valid   (redirect_valid),
      .redirect_pc      (redirect_pc),
      .imem_req         (imem_req),
      .imem_addr        (imem_addr),
      .imem_ready       (imem_ready),
      .imem_resp        (imem_resp),
      .imem_rdata       (imem_rdata),
      .queue_full_param (queue_full_param),
      .q_data_in        (q_data_in),
      .q_write_enable   (q_write_enable),
      .q_flush          (q_flush),
      .outstanding      (outstanding)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return a ^ 32'h5a5a_1234;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive the responder, update the model, then check outputs.
   task automatic step();
      logic        do_resp;
      logic        hs;
      logic        hold_exp;
      logic        we_exp;
      logic        flush_exp;
      logic [31:0] addr_pre;
      logic [63:0] exp_data;
      req_t        head;

      do_resp = rst && resp_en && (reqq.size() > 0);
      if (do_resp) begin
         imem_resp  = 1'b1;
         imem_rdata = instr_of(reqq[0].addr);
      end else begin
         imem_resp  = !rst && junk_resp;
         imem_rdata = 32'hdead_beef;
      end
      hs        = rst && imem_req && imem_ready;
      hold_exp  = rst && imem_req && !imem_ready && !redirect_valid;
      flush_exp = rst && redirect_valid;
      addr_pre  = imem_addr;
      we_exp    = 1'b0;

      if (!rst) begin
         reqq.delete();
         sb.delete();
         exp_pc = RST_PC;
      end else begin
         if (do_resp) begin
            head = reqq.pop_front();
            if (!head.stale && !redirect_valid) begin
               sb.push_back({head.addr, instr_of(head.addr)});
               we_exp = 1'b1;
            end
         end
         if (hs) begin
            chk("accept_addr", 64'(addr_pre), 64'(exp_pc));
            reqq.push_back('{addr: addr_pre, stale: redirect_valid});
            exp_pc = exp_pc + 32'd4;
         end
         if (redirect_valid) begin
            foreach (reqq[i]) reqq[i].stale = 1'b1;
            exp_pc = {redirect_pc[31:2], 2'b00};
         end
      end

      @(posedge clk);
      #1;
      imem_resp = 1'b0;

      chk("q_write_enable", 64'(q_write_enable), 64'(we_exp));
      chk("q_flush", 64'(q_flush), 64'(flush_exp));
      chk("outstanding", 64'(outstanding), 64'(reqq.size()));
      chk("outstanding_le_max", 64'(outstanding <= 3'd4), 64'(1));
      if (sb.size() > 0) begin
         exp_data = sb.pop_front();
         if (q_write_enable) chk("q_data_in", q_data_in, exp_data);
      end
      if (hold_exp) begin
         chk("hold_req", 64'(imem_req), 64'(1));
         chk("hold_addr", 64'(imem_addr), 64'(addr_pre));
      end
      if (flush_exp) chk("redirect_drops_req", 64'(imem_req), 64'(0));
      if (!rst) begin
         chk("rst_req", 64'(imem_req), 64'(0));
         chk("rst_addr", 64'(imem_addr), 64'(RST_PC));
         chk("rst_data", q_data_in, 64'(0));
      end
   endtask

   initial begin
      rst = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; imem_ready = 1'b0;
      imem_resp = 1'b0; imem_rdata = 32'h0; queue_full_param = 1'b0;
      resp_en = 1'b0; junk_resp = 1'b0; exp_pc = RST_PC;

      // Reset, then a stalled first request.
      step(); step();
      rst = 1'b1;
      step();
      chk("req_after_reset", 64'(imem_req), 64'(1));
      for (int i = 0; i < 5; i++) begin
         step();
         chk("stall_addr", 64'(imem_addr), 64'(RST_PC));
      end
      imem_ready = 1'b1;
      step();
      imem_ready = 1'b0;
      chk("single_advance", 64'(imem_addr), 64'(32'h1eceb004));
      chk("single_accept", 64'(outstanding), 64'(1));

      // Streaming with 1-cycle response latency, then hit the in-flight limit.
      imem_ready = 1'b1; resp_en = 1'b1;
      repeat (16) step();
      resp_en = 1'b0;
      repeat (8) step();
      chk("max_outstanding", 64'(outstanding), 64'(4));
      chk("max_no_req", 64'(imem_req), 64'(0));
      imem_ready = 1'b0; resp_en = 1'b1;
      for (int i = 0; i < 20 && reqq.size() > 0; i++) step();
      chk("drained", 64'(outstanding), 64'(0));

      // Queue almost full after three accepts.
      resp_en = 1'b0; imem_ready = 1'b1;
      for (int i = 0; i < 20 && reqq.size() < 2; i++) step();
      chk("wait_two_accepts", 64'(reqq.size()), 64'(2));
      queue_full_param = 1'b1;
      step();
      chk("qfull_three_out", 64'(outstanding), 64'(3));
      chk("qfull_stop_req", 64'(imem_req), 64'(0));
      resp_en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("qfull_no_req", 64'(imem_req), 64'(0));
      end
      queue_full_param = 1'b0;
      step();
      chk("qfull_resume", 64'(imem_req), 64'(1));

      // Redirect with three in flight: flush, drain, restart at new PC.
      resp_en = 1'b0;
      for (int i = 0; i < 20 && reqq.size() < 3; i++) step();
      chk("wait_three_accepts", 64'(reqq.size()), 64'(3));
      imem_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h1eceb100;
      step();
      redirect_valid = 1'b0; imem_ready = 1'b1; resp_en = 1'b1;
      for (int i = 0; i < 20 && reqq.size() > 0; i++) begin
         step();
         if (reqq.size() > 0) chk("drain_no_req", 64'(imem_req), 64'(0));
      end
      chk("drain_done_req", 64'(imem_req), 64'(1));
      chk("drain_done_addr", 64'(imem_addr), 64'(32'h1eceb100));
      for (int i = 0; i < 10 && !q_write_enable; i++) step();
      chk("redirect_first_we", 64'(q_write_enable), 64'(1));
      chk("redirect_first_pc", 64'(q_data_in[63:32]), 64'(32'h1eceb100));

      // Redirect coinciding with the only response: no DRAIN, aligned new PC.
      imem_ready = 1'b0;
      for (int i = 0; i < 20 && reqq.size() > 0; i++) step();
      imem_ready = 1'b1;
      step();
      chk("one_in_flight", 64'(outstanding), 64'(1));
      imem_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h1eceb202;
      step();
      chk("redirect_resp_out", 64'(outstanding), 64'(0));
      redirect_valid = 1'b0;
      step();
      chk("redirect_req_next", 64'(imem_req), 64'(1));
      chk("redirect_addr_aligned", 64'(imem_addr), 64'(32'h1eceb200));

      // Reset in the middle of DRAIN with two in flight.
      imem_ready = 1'b1; resp_en = 1'b0;
      for (int i = 0; i < 20 && reqq.size() < 2; i++) step();
      imem_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h1eceb300;
      step();
      redirect_valid = 1'b0;
      step();
      chk("drain_two_out", 64'(outstanding), 64'(2));
      rst = 1'b0; junk_resp = 1'b1;
      repeat (3) step();
      rst = 1'b1; junk_resp = 1'b0; resp_en = 1'b1; imem_ready = 1'b1;
      step();
      chk("post_rst_req", 64'(imem_req), 64'(1));
      chk("post_rst_addr", 64'(imem_addr), 64'(RST_PC));
      repeat (6) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
